// File: rtl/pool_sched_pkg.sv
// Shared definitions for the pooling job scheduler: descriptor layout,
// completion status codes and the scheduler state encoding.
package pool_sched_pkg;

    localparam int DESC_W     = 66;

    localparam int TYPE_LSB   = 0;
    localparam int TYPE_W     = 2;
    localparam int SIZE_LSB   = 2;
    localparam int SIZE_W     = 8;
    localparam int STRIDE_LSB = 10;
    localparam int STRIDE_W   = 8;
    localparam int HEIGHT_LSB = 18;
    localparam int HEIGHT_W   = 16;
    localparam int WIDTH_LSB  = 34;
    localparam int WIDTH_W    = 16;
    localparam int CHAN_LSB   = 50;
    localparam int CHAN_W     = 16;

    localparam logic [1:0] TYPE_RSVD     = 2'b11;

    localparam logic [1:0] STATUS_OK      = 2'b00;
    localparam logic [1:0] STATUS_BAD_CFG = 2'b01;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b10;
    localparam logic [1:0] STATUS_ABORT   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_CONFIG = 3'd2,
        S_START  = 3'd3,
        S_WAIT   = 3'd4,
        S_RESP   = 3'd5
    } sched_state_t;

    typedef struct packed {
        logic [CHAN_W-1:0]   channels;
        logic [WIDTH_W-1:0]  width;
        logic [HEIGHT_W-1:0] height;
        logic [STRIDE_W-1:0] stride;
        logic [SIZE_W-1:0]   size;
        logic [TYPE_W-1:0]   ptype;
    } pool_desc_t;

    function automatic pool_desc_t desc_unpack(input logic [DESC_W-1:0] d);
        pool_desc_t f;
        f.ptype    = d[TYPE_LSB   +: TYPE_W];
        f.size     = d[SIZE_LSB   +: SIZE_W];
        f.stride   = d[STRIDE_LSB +: STRIDE_W];
        f.height   = d[HEIGHT_LSB +: HEIGHT_W];
        f.width    = d[WIDTH_LSB  +: WIDTH_W];
        f.channels = d[CHAN_LSB   +: CHAN_W];
        return f;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the pointer
// and wraps; returns a one-hot grant plus the binary index of the winner.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_idx
);

    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    int   cand;
    logic found;

    // Walk the requesters in rotated order and keep the first active one.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (!found && 1'(req >> cand)) begin
                grant     = ONE << cand;
                grant_idx = IDW'(cand);
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pool_job_scheduler.sv
// Pooling job scheduler: arbitrates job descriptors from several requesters,
// validates them, programs and starts the pooling datapath, supervises it
// with a timeout/abort, and reports a completion per job.
//
// state  | meaning
// IDLE   | offering req_ready to the round-robin winner
// CHECK  | validating the latched descriptor
// CONFIG | loading pool_* configuration outputs
// START  | pool_start pulse, timeout timer loaded
// WAIT   | waiting for pool_done, abort or timeout
// RESP   | holding completion until cmpl_ready
module pool_job_scheduler
    import pool_sched_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int MAX_POOL_SIZE  = 3,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int IDW            = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DESC_W-1:0] req_desc,
    input  logic                      abort,
    output logic                      cmpl_valid,
    input  logic                      cmpl_ready,
    output logic [IDW-1:0]            cmpl_id,
    output logic [1:0]                cmpl_status,
    output logic                      pool_start,
    output logic                      pool_clear,
    input  logic                      pool_done,
    output logic [1:0]                pool_type,
    output logic [7:0]                pool_size,
    output logic [7:0]                pool_stride,
    output logic [15:0]               pool_height,
    output logic [15:0]               pool_width,
    output logic [15:0]               pool_channels,
    output logic                      sched_busy,
    output logic [15:0]               jobs_ok
);

    // Down-counter: loaded with TIMEOUT_CYCLES-1 so terminal count 0 lands
    // on the last permitted WAIT cycle.
    localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

    sched_state_t         state;
    logic [IDW-1:0]       last_grant;
    logic [NUM_REQ-1:0]   grant;
    logic [IDW-1:0]       grant_idx;
    pool_desc_t           sel_desc;
    pool_desc_t           job_desc;
    logic                 desc_ok;
    logic [TMR_W-1:0]     tmr;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (last_grant),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready  = (state == S_IDLE) ? grant : '0;
    assign sched_busy = (state != S_IDLE);
    assign sel_desc   = desc_unpack(DESC_W'(req_desc >> (int'(grant_idx) * DESC_W)));

    assign desc_ok = (job_desc.ptype != TYPE_RSVD)
                  && (job_desc.size != '0)
                  && (job_desc.size <= SIZE_W'(MAX_POOL_SIZE))
                  && (job_desc.stride != '0)
                  && (HEIGHT_W'(job_desc.size) <= job_desc.height)
                  && (WIDTH_W'(job_desc.size) <= job_desc.width)
                  && (job_desc.channels != '0);

    // Scheduler FSM with registered datapath and completion outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            last_grant    <= IDW'(NUM_REQ - 1);
            job_desc      <= '0;
            tmr           <= '0;
            cmpl_valid    <= 1'b0;
            cmpl_id       <= '0;
            cmpl_status   <= STATUS_OK;
            pool_start    <= 1'b0;
            pool_clear    <= 1'b0;
            pool_type     <= '0;
            pool_size     <= '0;
            pool_stride   <= '0;
            pool_height   <= '0;
            pool_width    <= '0;
            pool_channels <= '0;
            jobs_ok       <= '0;
        end else begin
            pool_start <= 1'b0;
            pool_clear <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|grant) begin
                        job_desc   <= sel_desc;
                        cmpl_id    <= grant_idx;
                        last_grant <= grant_idx;
                        state      <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (desc_ok) begin
                        state <= S_CONFIG;
                    end else begin
                        cmpl_status <= STATUS_BAD_CFG;
                        cmpl_valid  <= 1'b1;
                        state       <= S_RESP;
                    end
                end
                S_CONFIG: begin
                    pool_type     <= job_desc.ptype;
                    pool_size     <= job_desc.size;
                    pool_stride   <= job_desc.stride;
                    pool_height   <= job_desc.height;
                    pool_width    <= job_desc.width;
                    pool_channels <= job_desc.channels;
                    pool_start    <= 1'b1;
                    state         <= S_START;
                end
                S_START: begin
                    tmr <= TMR_LOAD;
                    if (abort) begin
                        pool_clear  <= 1'b1;
                        cmpl_status <= STATUS_ABORT;
                        cmpl_valid  <= 1'b1;
                        state       <= S_RESP;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (pool_done) begin
                        cmpl_status <= STATUS_OK;
                        cmpl_valid  <= 1'b1;
                        state       <= S_RESP;
                    end else if (abort) begin
                        pool_clear  <= 1'b1;
                        cmpl_status <= STATUS_ABORT;
                        cmpl_valid  <= 1'b1;
                        state       <= S_RESP;
                    end else if (tmr == '0) begin
                        pool_clear  <= 1'b1;
                        cmpl_status <= STATUS_TIMEOUT;
                        cmpl_valid  <= 1'b1;
                        state       <= S_RESP;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                S_RESP: begin
                    if (cmpl_ready) begin
                        cmpl_valid <= 1'b0;
                        state      <= S_IDLE;
                        if (cmpl_status == STATUS_OK && jobs_ok != 16'hFFFF)
                            jobs_ok <= jobs_ok + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pool_job_scheduler.sv
// Self-checking bench for pool_job_scheduler: directed scenarios followed by
// randomized jobs, all checked against a job-level reference model.
module tb_pool_job_scheduler;

    localparam int NUM_REQ  = 4;
    localparam int MAX_POOL = 3;
    localparam int TMO      = 16;
    localparam int IDW      = 2;
    localparam int DW       = 66;
    localparam int VW       = NUM_REQ * DW;

    localparam int M_DONE    = 0;
    localparam int M_ABORT   = 1;
    localparam int M_TIMEOUT = 2;
    localparam int M_RESET   = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    logic [VW-1:0]      req_desc;
    logic               abort;
    logic               cmpl_valid;
    logic               cmpl_ready;
    logic [IDW-1:0]     cmpl_id;
    logic [1:0]         cmpl_status;
    logic               pool_start;
    logic               pool_clear;
    logic               pool_done;
    logic [1:0]         pool_type;
    logic [7:0]         pool_size;
    logic [7:0]         pool_stride;
    logic [15:0]        pool_height;
    logic [15:0]        pool_width;
    logic [15:0]        pool_channels;
    logic               sched_busy;
    logic [15:0]        jobs_ok;

    always #5 clk = ~clk;

    pool_job_scheduler #(
        .NUM_REQ        (NUM_REQ),
        .MAX_POOL_SIZE  (MAX_POOL),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_desc      (req_desc),
        .abort         (abort),
        .cmpl_valid    (cmpl_valid),
        .cmpl_ready    (cmpl_ready),
        .cmpl_id       (cmpl_id),
        .cmpl_status   (cmpl_status),
        .pool_start    (pool_start),
        .pool_clear    (pool_clear),
        .pool_done     (pool_done),
        .pool_type     (pool_type),
        .pool_size     (pool_size),
        .pool_stride   (pool_stride),
        .pool_height   (pool_height),
        .pool_width    (pool_width),
        .pool_channels (pool_channels),
        .sched_busy    (sched_busy),
        .jobs_ok       (jobs_ok)
    );

    int          n_chk = 0;
    int          n_pass = 0;
    int          last_grant_m;
    int          jobs_ok_m;
    logic [65:0] cfg_m;
    logic [65:0] desc_drv [NUM_REQ];

    task automatic chk_eq(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [65:0] mk_desc(input int t, input int s, input int st,
                                            input int h, input int w, input int c);
        logic [65:0] d;
        d = {16'(c), 16'(w), 16'(h), 8'(st), 8'(s), 2'(t)};
        return d;
    endfunction

    function automatic bit desc_legal(input logic [65:0] d);
        int t, s, st, h, w, c;
        t  = int'(d[1:0]);
        s  = int'(d[9:2]);
        st = int'(d[17:10]);
        h  = int'(d[33:18]);
        w  = int'(d[49:34]);
        c  = int'(d[65:50]);
        return (t != 3) && (s >= 1) && (s <= MAX_POOL) && (st != 0)
            && (s <= h) && (s <= w) && (c != 0);
    endfunction

    function automatic logic [65:0] rand_desc(input bit legal);
        int          s;
        logic [65:0] d;
        s = int'($urandom_range(1, MAX_POOL));
        d = mk_desc(int'($urandom_range(0, 2)), s, int'($urandom_range(1, 4)),
                    int'($urandom_range(s, 20)), int'($urandom_range(s, 20)),
                    int'($urandom_range(1, 64)));
        if (!legal) begin
            case ($urandom_range(0, 6))
                0:       d[1:0]   = 2'b11;
                1:       d[9:2]   = 8'd0;
                2:       d[9:2]   = 8'($urandom_range(MAX_POOL + 1, 255));
                3:       d[17:10] = 8'd0;
                4:       d[33:18] = 16'(s - 1);
                5:       d[49:34] = 16'(s - 1);
                default: d[65:50] = 16'd0;
            endcase
        end
        return d;
    endfunction

    // Lowest active requester above the previous grant, otherwise lowest overall.
    function automatic int pick_winner(input logic [NUM_REQ-1:0] mask);
        int w;
        w = -1;
        for (int c = NUM_REQ - 1; c > last_grant_m; c--) if (mask[c]) w = c;
        if (w < 0) for (int c = last_grant_m; c >= 0; c--) if (mask[c]) w = c;
        return w;
    endfunction

    function automatic logic [VW-1:0] pack_descs();
        logic [VW-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_REQ; k++) v[k*DW +: DW] = desc_drv[k];
        return v;
    endfunction

    function automatic logic [65:0] cfg_now();
        return {pool_channels, pool_width, pool_height, pool_stride, pool_size, pool_type};
    endfunction

    task automatic drive_idle();
        req_valid  = '0;
        abort      = 1'b0;
        pool_done  = 1'b0;
        cmpl_ready = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk_eq({tag, "_ctl"}, {cmpl_valid, cmpl_status, cmpl_id, pool_start,
                               pool_clear, sched_busy, req_ready}, '0);
        chk_eq({tag, "_cfg"}, cfg_now(), '0);
        chk_eq({tag, "_jobs"}, jobs_ok, '0);
    endtask

    task automatic run_job(input logic [NUM_REQ-1:0] mask, input logic [65:0] wdesc,
                           input int mode, input int when, input int rdy,
                           input bit both, input bit noise);
        int                 w, e, k_hs;
        bit                 legal, clr;
        logic [1:0]         st;
        logic [65:0]        cfg_old, cfg_new;
        logic [NUM_REQ-1:0] oh;
        logic [31:0]        r;
        w = pick_winner(mask);
        for (int k = 0; k < NUM_REQ; k++)
            desc_drv[k] = (k == w) ? wdesc : rand_desc(1'($urandom_range(0, 1)));
        legal = desc_legal(wdesc);
        clr = 1'b0;
        st  = 2'b00;
        e   = 1000;
        if (!legal) begin
            st = 2'b01; e = 2;
        end else begin
            case (mode)
                M_DONE:    begin st = 2'b00; e = 5 + when; end
                M_ABORT:   begin st = 2'b11; e = (when < 0) ? 4 : 5 + when; clr = 1'b1; end
                M_TIMEOUT: begin st = 2'b10; e = 4 + TMO; clr = 1'b1; end
                default:   e = 1000;
            endcase
        end
        k_hs    = e + rdy;
        cfg_old = cfg_m;
        cfg_new = legal ? wdesc : cfg_m;
        oh      = '0;
        oh[w]   = 1'b1;

        @(negedge clk);
        req_valid  = mask;
        req_desc   = pack_descs();
        abort      = noise & 1'($urandom_range(0, 1));
        pool_done  = 1'b0;
        cmpl_ready = 1'b0;
        #1;
        chk_eq("grant", req_ready, oh);
        chk_eq("busy_idle", sched_busy, 0);
        last_grant_m = w;

        for (int k = 1; k <= k_hs; k++) begin
            @(negedge clk);
            if (legal && mode == M_RESET && k == 4 + when) begin
                drive_idle();
                rst_n = 1'b0;
                #1;
                chk_zero("rst_async");
                @(negedge clk);
                chk_zero("rst_held");
                rst_n = 1'b1;
                last_grant_m = NUM_REQ - 1;
                jobs_ok_m    = 0;
                cfg_m        = '0;
                return;
            end
            r          = $urandom;
            req_valid  = (k >= e) ? r[NUM_REQ-1:0] : '0;
            pool_done  = legal && mode == M_DONE && k == 4 + when;
            if (legal && mode == M_ABORT && k == ((when < 0) ? 3 : 4 + when))
                abort = 1'b1;
            else if (legal && mode == M_DONE && both && k == 4 + when)
                abort = 1'b1;
            else if (noise && (k < 3 || k >= e))
                abort = r[31];
            else
                abort = 1'b0;
            cmpl_ready = (k == k_hs);
            #1;
            chk_eq("ready_busy", req_ready, 0);
            chk_eq("busy", sched_busy, 1);
            chk_eq("start", pool_start, legal && k == 3);
            chk_eq("clear", pool_clear, clr && k == e);
            chk_eq("cvalid", cmpl_valid, k >= e);
            if (k >= e) begin
                chk_eq("cid", cmpl_id, w);
                chk_eq("cstat", cmpl_status, st);
            end
            chk_eq("cfg", cfg_now(), (legal && k >= 3) ? cfg_new : cfg_old);
            chk_eq("jobs_ok", jobs_ok, jobs_ok_m);
        end
        if (st == 2'b00 && jobs_ok_m < 16'hFFFF) jobs_ok_m++;
        cfg_m = cfg_new;

        @(negedge clk);
        drive_idle();
        #1;
        chk_eq("idle_busy", sched_busy, 0);
        chk_eq("idle_cvalid", cmpl_valid, 0);
        chk_eq("idle_clear", pool_clear, 0);
        chk_eq("idle_jobs", jobs_ok, jobs_ok_m);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [65:0] good;
        int          mode, when;
        bit          legal;

        rst_n    = 1'b0;
        req_desc = '0;
        drive_idle();
        last_grant_m = NUM_REQ - 1;
        jobs_ok_m    = 0;
        cfg_m        = '0;
        for (int k = 0; k < NUM_REQ; k++) desc_drv[k] = '0;
        repeat (2) @(negedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        good = mk_desc(0, 2, 2, 8, 8, 16);

        // Requesters 0 and 2 alternate, done five cycles after start.
        repeat (4) run_job(4'b0101, good, M_DONE, 4, 0, 1'b0, 1'b0);
        chk_eq("jobs_ok_after4", jobs_ok, 4);

        // Oversized window is rejected without touching the datapath.
        run_job(4'b0010, mk_desc(0, 4, 1, 8, 8, 16), M_DONE, 0, 1, 1'b0, 1'b0);

        // 2x2 stride 2 on 8x8x16.
        run_job(4'b1000, good, M_DONE, 3, 2, 1'b0, 1'b0);

        // Timeout after TMO wait cycles.
        run_job(4'b0001, good, M_TIMEOUT, 0, 1, 1'b0, 1'b0);

        // Abort colliding with done, completion held for 10 cycles.
        run_job(4'b0100, good, M_DONE, 2, 10, 1'b1, 1'b0);

        // Abort during START and at the last wait cycle.
        run_job(4'b0010, good, M_ABORT, -1, 0, 1'b0, 1'b1);
        run_job(4'b0010, good, M_ABORT, TMO - 1, 0, 1'b0, 1'b1);

        // Reset mid-wait, then requester 0 wins first.
        run_job(4'b0110, good, M_RESET, 3, 0, 1'b0, 1'b0);
        run_job(4'b1111, good, M_DONE, 0, 0, 1'b0, 1'b0);

        repeat (40) begin
            legal = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 9))
                5, 6, 7: mode = M_ABORT;
                8:       mode = M_TIMEOUT;
                default: mode = M_DONE;
            endcase
            when = (mode == M_ABORT) ? int'($urandom_range(0, TMO)) - 1
                                     : int'($urandom_range(0, TMO - 1));
            run_job(4'($urandom_range(1, 15)), rand_desc(legal), mode, when,
                    int'($urandom_range(0, 4)),
                    (mode == M_DONE) && ($urandom_range(0, 1) == 1), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
